// File: rtl/text_display.sv
// -----------------------------------------------------------------------------
// text_display
//   Character-cell text renderer. Keeps a COLS x ROWS buffer of {char, attr}
//   cells, filled from a byte stream that understands a few terminal control
//   codes, and turns the VGA controller's pixel row/column into RGB through a
//   fixed three-stage pipeline using 8x16 glyphs from font_rom.
//
// Ports
//   iClk_50      system clock
//   iRst         synchronous active-high reset (restarts the clear sweep)
//   iRow, iCol   pixel coordinate from the VGA controller
//   oRed/oGreen/oBlue  pixel colour, valid 3 clocks after iRow/iCol
//   iChar_Valid, iChar, iAttr, oChar_Ready  byte stream handshake
//   iCursor_En   show the blinking cursor
//   oCursor_Col, oCursor_Row  current cursor cell
//   oBusy        high while the buffer is being cleared
//
// Also contains font_rom, the combinational 8x16 glyph table.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// font_rom
//   Combinational glyph lookup. oLine bit 0 is the leftmost pixel of the line.
//   Ports: iChar glyph code, iRow glyph line (0..15), oLine pixel bits.
//   Space is blank, 'A' has a drawn glyph; every other code shows its own
//   byte value on lines 2..13 so each glyph stays distinguishable.
// -----------------------------------------------------------------------------
module font_rom (
  input  logic [7:0] iChar,
  input  logic [3:0] iRow,
  output logic [7:0] oLine
);

  always_comb begin
    oLine = 8'h00;
    if (iChar == 8'h41) begin
      case (iRow)
        4'd2:                      oLine = 8'h18;
        4'd3:                      oLine = 8'h3C;
        4'd4, 4'd5, 4'd6:          oLine = 8'h66;
        4'd7, 4'd8:                oLine = 8'h7E;
        4'd9, 4'd10, 4'd11, 4'd12: oLine = 8'h66;
        default:                   oLine = 8'h00;
      endcase
    end else if (iChar != 8'h20) begin
      if (iRow >= 4'd2 && iRow <= 4'd13) begin
        oLine = iChar;
      end
    end
  end

endmodule

module text_display #(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 30,
  parameter int         COLOR_W      = 10,
  parameter int         COLOR_MAX    = 1000,
  parameter int         BLINK_DIV    = 25000000,
  parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
  input  logic                     iClk_50,
  input  logic                     iRst,
  input  logic [9:0]               iRow,
  input  logic [9:0]               iCol,
  output logic [COLOR_W-1:0]       oRed,
  output logic [COLOR_W-1:0]       oGreen,
  output logic [COLOR_W-1:0]       oBlue,
  input  logic                     iChar_Valid,
  input  logic [7:0]               iChar,
  input  logic [7:0]               iAttr,
  output logic                     oChar_Ready,
  input  logic                     iCursor_En,
  output logic [$clog2(COLS)-1:0]  oCursor_Col,
  output logic [$clog2(ROWS)-1:0]  oCursor_Row,
  output logic                     oBusy
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  // ---------------------------------------------------------------------------
  // Stream / clear control state
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic [CW-1:0]   cur_col_q, cur_col_d;
  logic [RW-1:0]   cur_row_q, cur_row_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [15:0]     wr_data;
  logic [AW-1:0]   cursor_addr;

  // Blink timebase
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_phase_q, blink_phase_d;

  // Render pipeline
  logic [6:0]      s0_cell_col_q, s0_cell_col_d;
  logic [5:0]      s0_cell_row_q, s0_cell_row_d;
  logic [2:0]      s0_gx_q, s0_gx_d;
  logic [3:0]      s0_gy_q, s0_gy_d;
  logic            s0_oob_q, s0_oob_d;

  logic [AW-1:0]   rd_addr;
  logic [15:0]     rd_data_q;
  logic [2:0]      s1_gx_q, s1_gx_d;
  logic [3:0]      s1_gy_q, s1_gy_d;
  logic            s1_oob_q, s1_oob_d;
  logic            s1_hit_q, s1_hit_d;

  logic [7:0]      font_line;
  logic [7:0]      cell_attr;
  logic            pixel_on;
  logic [2:0]      fg_rgb, bg_rgb, sel_rgb;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  // Attribute bit 3 is stored but has no visual meaning yet.
  logic            unused_attr_bit;
  assign unused_attr_bit = cell_attr[3];

  logic [15:0]     mem [CELLS];

  assign cursor_addr = AW'(cur_row_q) * AW'(COLS) + AW'(cur_col_q);

  // ---------------------------------------------------------------------------
  // Next-state logic for the stream/clear FSM and cursor. Both the clear sweep
  // and printable bytes share the single buffer write port; the FSM guarantees
  // they never want it in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;
    wr_en      = 1'b0;
    wr_addr    = clr_addr_q;
    wr_data    = {8'h20, DEFAULT_ATTR};

    case (state_q)
      S_CLEAR: begin
        wr_en = 1'b1;
        if (clr_addr_q == AW'(CELLS - 1)) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end

      default: begin
        if (iChar_Valid && ready_q) begin
          case (iChar)
            8'h0D: cur_col_d = '0;
            8'h0A: cur_row_d = (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
            8'h08: begin
              if (cur_col_q != '0) begin
                cur_col_d = cur_col_q - CW'(1);
              end
            end
            8'h0C: begin
              cur_col_d  = '0;
              cur_row_d  = '0;
              clr_addr_d = '0;
              state_d    = S_CLEAR;
            end
            default: begin
              wr_en   = 1'b1;
              wr_addr = cursor_addr;
              wr_data = {iChar, iAttr};
              // No scrolling: the last cell wraps back to the home position.
              if (cur_col_q == CW'(COLS - 1)) begin
                cur_col_d = '0;
                cur_row_d = (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
              end else begin
                cur_col_d = cur_col_q + CW'(1);
              end
            end
          endcase
        end
      end
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Blink timebase: phase flips each time the counter wraps.
  // ---------------------------------------------------------------------------
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Render stage 0: split the pixel coordinate into cell and glyph offsets.
  // ---------------------------------------------------------------------------
  always_comb begin
    s0_cell_col_d = iCol[9:3];
    s0_cell_row_d = iRow[9:4];
    s0_gx_d       = iCol[2:0];
    s0_gy_d       = iRow[3:0];
    s0_oob_d      = (32'(iCol) >= 32'(COLS * 8)) || (32'(iRow) >= 32'(ROWS * 16));
  end

  // ---------------------------------------------------------------------------
  // Render stage 1: buffer read address and cursor hit. Off-screen coordinates
  // read address 0 so the memory is never indexed past its end; their colour
  // is forced to black later anyway.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_addr  = s0_oob_q ? '0
                        : AW'(s0_cell_row_q) * AW'(COLS) + AW'(s0_cell_col_q);
    s1_gx_d  = s0_gx_q;
    s1_gy_d  = s0_gy_q;
    s1_oob_d = s0_oob_q;
    s1_hit_d = ({3'b000, s0_cell_col_q} == 10'(cur_col_q)) &&
               ({4'b0000, s0_cell_row_q} == 10'(cur_row_q)) &&
               iCursor_En && blink_phase_q;
  end

  font_rom u_font (
    .iChar (rd_data_q[15:8]),
    .iRow  (s1_gy_q),
    .oLine (font_line)
  );

  // ---------------------------------------------------------------------------
  // Render stage 2: glyph pixel, text blink, cursor inversion, colour expand.
  // ---------------------------------------------------------------------------
  always_comb begin
    cell_attr = rd_data_q[7:0];
    pixel_on  = font_line[s1_gx_q];
    if (cell_attr[7] && !blink_phase_q) begin
      pixel_on = 1'b0;
    end
    fg_rgb = cell_attr[2:0];
    bg_rgb = cell_attr[6:4];
    if (s1_hit_q) begin
      fg_rgb = cell_attr[6:4];
      bg_rgb = cell_attr[2:0];
    end
    sel_rgb = pixel_on ? fg_rgb : bg_rgb;
    if (s1_oob_q) begin
      sel_rgb = 3'b000;
    end
    red_d   = sel_rgb[2] ? COLOR_W'(COLOR_MAX) : '0;
    green_d = sel_rgb[1] ? COLOR_W'(COLOR_MAX) : '0;
    blue_d  = sel_rgb[0] ? COLOR_W'(COLOR_MAX) : '0;
  end

  // ---------------------------------------------------------------------------
  // All control and pipeline registers. Reset starts a clear from address 0,
  // so a reset in the middle of a sweep simply begins it again.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk_50) begin
    if (iRst) begin
      state_q       <= S_CLEAR;
      clr_addr_q    <= '0;
      cur_col_q     <= '0;
      cur_row_q     <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b1;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      s0_cell_col_q <= '0;
      s0_cell_row_q <= '0;
      s0_gx_q       <= '0;
      s0_gy_q       <= '0;
      s0_oob_q      <= 1'b0;
      s1_gx_q       <= '0;
      s1_gy_q       <= '0;
      s1_oob_q      <= 1'b0;
      s1_hit_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      cur_col_q     <= cur_col_d;
      cur_row_q     <= cur_row_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      s0_cell_col_q <= s0_cell_col_d;
      s0_cell_row_q <= s0_cell_row_d;
      s0_gx_q       <= s0_gx_d;
      s0_gy_q       <= s0_gy_d;
      s0_oob_q      <= s0_oob_d;
      s1_gx_q       <= s1_gx_d;
      s1_gy_q       <= s1_gy_d;
      s1_oob_q      <= s1_oob_d;
      s1_hit_q      <= s1_hit_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Simple dual-port cell buffer. A read of the address being written returns
  // the old contents, which is harmless for display.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk_50) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign oRed        = red_q;
  assign oGreen      = green_q;
  assign oBlue       = blue_q;
  assign oChar_Ready = ready_q;
  assign oBusy       = busy_q;
  assign oCursor_Col = cur_col_q;
  assign oCursor_Row = cur_row_q;

endmodule

// File: tb/tb_text_display.sv
// -----------------------------------------------------------------------------
// tb_text_display
//   Directed bench for text_display (80x30, blink divider shortened to 4).
//   Pixel checks come from a table of {row, col, expected RGB}; clear timing,
//   cursor movement, blinking and reset-during-clear use short sequences.
// -----------------------------------------------------------------------------
module tb_text_display;

  localparam int CMAX = 1000;

  logic       clk = 1'b0;
  logic       iRst;
  logic [9:0] iRow, iCol;
  logic [9:0] oRed, oGreen, oBlue;
  logic       iChar_Valid;
  logic [7:0] iChar, iAttr;
  logic       oChar_Ready;
  logic       iCursor_En;
  logic [6:0] oCursor_Col;
  logic [4:0] oCursor_Row;
  logic       oBusy;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [9:0] row;
    logic [9:0] col;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } vec_t;

  vec_t vecs[16];

  text_display #(
    .COLS         (80),
    .ROWS         (30),
    .COLOR_W      (10),
    .COLOR_MAX    (1000),
    .BLINK_DIV    (4),
    .DEFAULT_ATTR (8'h07)
  ) dut (
    .iClk_50     (clk),
    .iRst        (iRst),
    .iRow        (iRow),
    .iCol        (iCol),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .iChar_Valid (iChar_Valid),
    .iChar       (iChar),
    .iAttr       (iAttr),
    .oChar_Ready (oChar_Ready),
    .iCursor_En  (iCursor_En),
    .oCursor_Col (oCursor_Col),
    .oCursor_Row (oCursor_Row),
    .oBusy       (oBusy)
  );

  always #10 clk = ~clk;

  // Hard stop in case something never settles.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present a pixel coordinate and wait out the 3-clock render latency.
  task automatic applyStimulus(input logic [9:0] row, input logic [9:0] col);
    iRow = row;
    iCol = col;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] c, input logic [7:0] a);
    iChar_Valid = 1'b1;
    iChar       = c;
    iAttr       = a;
    @(posedge clk);
    #1;
    iChar_Valid = 1'b0;
  endtask

  task automatic checkCursor(input string name, input int col, input int row);
    checkOutput({name, "_col"}, 32'(oCursor_Col), col);
    checkOutput({name, "_row"}, 32'(oCursor_Row), row);
  endtask

  // Count busy cycles of a clear; optionally offers bytes during the first
  // spam cycles, which must be ignored.
  task automatic waitClear(input string name, input int spam);
    int n;
    n = 0;
    while (oBusy === 1'b1 && n < 5000) begin
      iChar_Valid = (n < spam);
      iChar       = 8'h42;
      iAttr       = 8'h77;
      @(posedge clk);
      #1;
      n++;
    end
    iChar_Valid = 1'b0;
    checkOutput({name, "_busy_cycles"}, n, 2400);
    checkOutput({name, "_ready"}, 32'(oChar_Ready), 1);
  endtask

  // Sample one channel for 24 cycles and require runs of 4 alternating
  // between 0 and onVal.
  task automatic checkBlink(input string name, input logic [9:0] row,
                            input logic [9:0] col, input int chan, input int onVal);
    int s[24];
    int t;
    int bad;
    int other;
    applyStimulus(row, col);
    for (int i = 0; i < 24; i++) begin
      s[i] = (chan == 0) ? int'(oRed) : (chan == 1) ? int'(oGreen) : int'(oBlue);
      @(posedge clk);
      #1;
    end
    t   = 0;
    bad = 0;
    for (int i = 1; i < 9; i++) begin
      if (t == 0 && s[i] != s[i-1]) t = i;
    end
    if (t == 0) begin
      bad = 1;
    end else begin
      other = (s[t] == onVal) ? 0 : onVal;
      if (s[t] != 0 && s[t] != onVal) bad = 1;
      for (int k = 0; k < 16; k++) begin
        if (s[t+k] != (((k / 4) % 2 == 0) ? s[t] : other)) bad = 1;
      end
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL %s: got samples %0d %0d %0d %0d %0d %0d %0d %0d %0d %0d, expected runs of 4 alternating 0/%0d",
               name, s[0], s[1], s[2], s[3], s[4], s[5], s[6], s[7], s[8], s[9], onVal);
    end
  endtask

  initial begin
    int nonBlack;

    // Pixel table, valid once row 0 holds 'A'(04) then 79 x 'B'(21) and
    // cell (0,2) holds 'B'(21). 'A' line 2 = 18h, line 7 = 7Eh; 'B' lines
    // 2..13 = 42h (pixels x=1 and x=6). Attr 21: fg blue, bg green.
    vecs[0]  = '{row: 10'd2,   col: 10'd3,   r: 10'd1000, g: 10'd0,    b: 10'd0};
    vecs[1]  = '{row: 10'd2,   col: 10'd0,   r: 10'd0,    g: 10'd0,    b: 10'd0};
    vecs[2]  = '{row: 10'd7,   col: 10'd1,   r: 10'd1000, g: 10'd0,    b: 10'd0};
    vecs[3]  = '{row: 10'd7,   col: 10'd0,   r: 10'd0,    g: 10'd0,    b: 10'd0};
    vecs[4]  = '{row: 10'd0,   col: 10'd3,   r: 10'd0,    g: 10'd0,    b: 10'd0};
    vecs[5]  = '{row: 10'd15,  col: 10'd7,   r: 10'd0,    g: 10'd0,    b: 10'd0};
    vecs[6]  = '{row: 10'd5,   col: 10'd9,   r: 10'd0,    g: 10'd0,    b: 10'd1000};
    vecs[7]  = '{row: 10'd5,   col: 10'd8,   r: 10'd0,    g: 10'd1000, b: 10'd0};
    vecs[8]  = '{row: 10'd5,   col: 10'd14,  r: 10'd0,    g: 10'd0,    b: 10'd1000};
    vecs[9]  = '{row: 10'd5,   col: 10'd15,  r: 10'd0,    g: 10'd1000, b: 10'd0};
    vecs[10] = '{row: 10'd5,   col: 10'd633, r: 10'd0,    g: 10'd0,    b: 10'd1000};
    vecs[11] = '{row: 10'd21,  col: 10'd640, r: 10'd0,    g: 10'd0,    b: 10'd0};
    vecs[12] = '{row: 10'd37,  col: 10'd1,   r: 10'd0,    g: 10'd0,    b: 10'd1000};
    vecs[13] = '{row: 10'd37,  col: 10'd9,   r: 10'd0,    g: 10'd0,    b: 10'd0};
    vecs[14] = '{row: 10'd480, col: 10'd0,   r: 10'd0,    g: 10'd0,    b: 10'd0};
    vecs[15] = '{row: 10'd21,  col: 10'd1,   r: 10'd0,    g: 10'd0,    b: 10'd0};

    iRst        = 1'b1;
    iRow        = '0;
    iCol        = '0;
    iChar_Valid = 1'b0;
    iChar       = '0;
    iAttr       = '0;
    iCursor_En  = 1'b0;

    // Reset state, then the power-on clear with a byte held valid throughout.
    repeat (2) @(posedge clk);
    #1;
    iRst = 1'b0;
    checkOutput("rst_busy", 32'(oBusy), 1);
    checkOutput("rst_ready", 32'(oChar_Ready), 0);
    checkOutput("rst_red", 32'(oRed), 0);
    checkOutput("rst_green", 32'(oGreen), 0);
    checkOutput("rst_blue", 32'(oBlue), 0);
    checkCursor("rst_cursor", 0, 0);
    waitClear("init_clear", 5000);

    // Pipelined sparse scan of the cleared frame: everything must be black.
    nonBlack = 0;
    for (int i = 0; i < 300; i++) begin
      iRow = 10'((i * 37) % 480);
      iCol = 10'((i * 53) % 640);
      @(posedge clk);
      #1;
      if (i >= 3 && (oRed | oGreen | oBlue) != 10'd0) nonBlack++;
    end
    checkOutput("blank_scan_nonblack", nonBlack, 0);

    // First row of text, then line control codes.
    sendByte(8'h41, 8'h04);
    checkCursor("after_A", 1, 0);
    sendByte(8'h42, 8'h21);
    checkCursor("after_B", 2, 0);
    for (int i = 0; i < 78; i++) sendByte(8'h42, 8'h21);
    checkCursor("row_wrap", 0, 1);
    sendByte(8'h0A, 8'h07);
    checkCursor("lf", 0, 2);
    sendByte(8'h0D, 8'h07);
    checkCursor("cr_at_col0", 0, 2);
    sendByte(8'h08, 8'h07);
    checkCursor("bs_at_col0", 0, 2);
    sendByte(8'h42, 8'h21);
    checkCursor("write_row2", 1, 2);
    sendByte(8'h0D, 8'h07);
    checkCursor("cr", 0, 2);
    sendByte(8'h41, 8'h21);
    sendByte(8'h08, 8'h07);
    checkCursor("bs", 0, 2);
    for (int i = 0; i < 27; i++) sendByte(8'h0A, 8'h07);
    checkCursor("lf_last_row", 0, 29);
    sendByte(8'h0A, 8'h07);
    checkCursor("lf_wrap", 0, 0);
    sendByte(8'h0A, 8'h07);
    sendByte(8'h0A, 8'h07);
    checkCursor("lf_back", 0, 2);
    // Re-write (0,2) as 'B' over the 'A' left there, then step back.
    sendByte(8'h42, 8'h21);
    sendByte(8'h08, 8'h07);
    checkCursor("bs_again", 0, 2);

    // Exact render latency: a black pixel, then a red one.
    applyStimulus(10'd0, 10'd0);
    iRow = 10'd2;
    iCol = 10'd3;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("latency_2clk_red", 32'(oRed), 0);
    @(posedge clk);
    #1;
    checkOutput("latency_3clk_red", 32'(oRed), CMAX);

    // Table-driven pixel checks.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].row, vecs[i].col);
      checkOutput($sformatf("vec%0d_red", i), 32'(oRed), 32'(vecs[i].r));
      checkOutput($sformatf("vec%0d_green", i), 32'(oGreen), 32'(vecs[i].g));
      checkOutput($sformatf("vec%0d_blue", i), 32'(oBlue), 32'(vecs[i].b));
    end

    // Fill the remaining 2240 cells from (0,2): cursor must wrap home.
    for (int i = 0; i < 2240; i++) begin
      iChar_Valid = 1'b1;
      iChar       = 8'h2E;
      iAttr       = 8'h07;
      @(posedge clk);
      #1;
      if (i == 2238) checkCursor("last_cell", 79, 29);
    end
    iChar_Valid = 1'b0;
    checkCursor("full_wrap", 0, 0);

    // Blinking text: 'B' with attr 87 at (0,0), pixel x=1 y=5 lit only in phase 1.
    sendByte(8'h42, 8'h87);
    checkCursor("blink_cell", 1, 0);
    checkBlink("blink_text_red", 10'd5, 10'd1, 0, CMAX);

    // Cursor on cell (1,0) ('B' attr 21): blank line shows bg green, and blue
    // when inverted.
    iCursor_En = 1'b1;
    checkBlink("cursor_green", 10'd0, 10'd8, 1, CMAX);
    checkBlink("cursor_blue", 10'd0, 10'd8, 2, CMAX);
    iCursor_En = 1'b0;

    // Form feed: clear with bytes offered during the sweep.
    sendByte(8'h0C, 8'h07);
    checkOutput("ff_ready", 32'(oChar_Ready), 0);
    checkOutput("ff_busy", 32'(oBusy), 1);
    checkCursor("ff_cursor", 0, 0);
    waitClear("ff_clear", 100);
    applyStimulus(10'd0, 10'd0);
    checkOutput("ff_cell0_red", 32'(oRed), 0);
    checkOutput("ff_cell0_green", 32'(oGreen), 0);
    applyStimulus(10'd5, 10'd1);
    checkOutput("ff_cell0_glyph", 32'(oRed), 0);
    applyStimulus(10'd0, 10'd8);
    checkOutput("ff_cell1_green", 32'(oGreen), 0);

    // Reset at address 1000 of a clear restarts the full sweep.
    sendByte(8'h0C, 8'h07);
    repeat (1000) @(posedge clk);
    #1;
    checkOutput("mid_clear_busy", 32'(oBusy), 1);
    iRst = 1'b1;
    @(posedge clk);
    #1;
    iRst = 1'b0;
    checkOutput("rst_mid_busy", 32'(oBusy), 1);
    checkOutput("rst_mid_ready", 32'(oChar_Ready), 0);
    waitClear("rst_mid_clear", 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/text_display.md
Name: text_display

Overview:
- Parametrised character-cell text renderer. Successor to the single-glyph display top.
- Holds a COLS x ROWS character/attribute buffer, fed by a byte-stream terminal interface with cursor and control codes, plus a hardware clear-screen sequencer.
- Converts the VGA controller's row/column into RGB through a fixed 3-cycle pipeline using the existing font_rom (8x16 glyphs).
- Sits between vga_controller (consumes oRow/oCol, drives iRed/iGreen/iBlue) and a host/UART producer.

Parameters:
- COLS, 80, character columns.
- ROWS, 30, character rows.
- COLOR_W, 10, width of each colour channel.
- COLOR_MAX, 1000, channel value for an "on" colour bit.
- BLINK_DIV, 25000000, clock cycles per blink-phase toggle.
- DEFAULT_ATTR, 8'h07, attribute written by clear (white on black).

Ports:
- iClk_50, in, 1, system clock.
- iRst, in, 1, synchronous active-high reset.
- iRow, in, 10, pixel row from vga_controller.
- iCol, in, 10, pixel column from vga_controller.
- oRed, out, COLOR_W, red pixel value.
- oGreen, out, COLOR_W, green pixel value.
- oBlue, out, COLOR_W, blue pixel value.
- iChar_Valid, in, 1, stream byte valid.
- iChar, in, 8, stream byte (glyph or control code).
- iAttr, in, 8, attribute: [2:0] fg RGB, [6:4] bg RGB, [7] blink text, [3] reserved.
- oChar_Ready, out, 1, block can accept a byte.
- iCursor_En, in, 1, show cursor.
- oCursor_Col, out, clog2(COLS), cursor column.
- oCursor_Row, out, clog2(ROWS), cursor row.
- oBusy, out, 1, clear in progress.

Behaviour:
- Reset (iRst high at clock edge):
  - oRed/oGreen/oBlue = 0; cursor = (0,0); blink counter and phase = 0.
  - FSM enters CLEAR with address 0; oBusy = 1 and oChar_Ready = 0 from the first post-reset cycle.
  - Reset during CLEAR restarts the sweep at address 0.
- FSM IDLE:
  - oChar_Ready = 1, oBusy = 0.
  - A byte is accepted when iChar_Valid && oChar_Ready at a clock edge.
- FSM CLEAR:
  - Writes {0x20, DEFAULT_ATTR} to one address per cycle, for addresses 0..COLS*ROWS-1.
  - Returns to IDLE the cycle after the last address is written, so the sweep takes COLS*ROWS cycles.
  - oChar_Ready = 0; stream input is ignored.
- Accepted byte handling (cursor updates take effect the next cycle):
  - 0x0D CR: col = 0.
  - 0x0A LF: row = row+1; wraps ROWS-1 -> 0; col unchanged.
  - 0x08 BS: col = col-1 if col > 0, else no change. The buffer is not modified.
  - 0x0C FF: cursor = (0,0); go to CLEAR; oChar_Ready falls the next cycle.
  - Any other byte: write {iChar, iAttr} at row*COLS+col, then advance col. At col COLS-1: col = 0, row+1. At the last cell: wrap to (0,0). No scrolling.
- Render pipeline (latency exactly 3 clocks from iRow/iCol to RGB):
  - S0: register cell col = iCol>>3, cell row = iRow>>4, glyph x = iCol[2:0], glyph y = iRow[3:0]. Set the out-of-range flag if iCol >= COLS*8 or iRow >= ROWS*16.
  - S1: synchronous buffer read at cell row*COLS + cell col. Cursor-hit = cell matches cursor && iCursor_En && blink phase.
  - S2: font_rom(iChar = buffer char, iRow = glyph y). Pixel = line[glyph x] (bit 0 is the leftmost pixel).
    - If attr[7] and blink phase = 0, pixel is forced to 0.
    - If cursor-hit, fg and bg are swapped.
    - Each channel = COLOR_MAX if the selected colour bit is set, else 0 (fg bit2 = R, bit1 = G, bit0 = B; bg likewise).
    - Out-of-range pixels produce 0 on all channels.
- Buffer:
  - Simple dual-port memory: one write port (stream or clear), one read port (render).
  - Read-during-write to the same address returns the old data; no stall is needed.
- Blink:
  - Counter counts 0..BLINK_DIV-1; phase toggles on wrap.

Test Plan:
- Reset, then hold iChar_Valid -> oBusy high for exactly 2400 cycles (80x30); oChar_Ready rises on cycle 2401; a full-frame scan is all black (attr 07, space glyph).
- Stream 'A' with attr 8'h04 at (0,0) -> cursor becomes (1,0); pixels at rows 0-15, cols 0-7 show R = 1000 where the font bit is set, else 0; G = B = 0; RGB appears 3 cycles after iRow/iCol.
- Stream 80 printable bytes, then LF, then CR -> cursor goes (0,1) after the 80th byte, (0,2) after LF, and stays (0,2) after CR. BS at col 0 changes nothing.
- Send 2400 printable bytes -> cursor wraps to (0,0). Send 0x0C -> oChar_Ready low the next cycle; bytes presented during the clear are not written; the buffer reads back as spaces.
- iCursor_En = 1, BLINK_DIV = 4 (test override) -> the cursor cell colours invert every 4 cycles; a cell with attr 8'h87 shows no glyph pixels while phase = 0.
- Assert iRst at address 1000 of a clear -> the sweep restarts at 0 and oBusy stays high for another 2400 cycles. iCol = 640 or iRow = 480 -> RGB = 0.
